dm_cache_ctrl: RTL and testbench
================================

Name: dm_cache_ctrl

Overview:
Parametrised, read-only, direct-mapped cache controller with valid/tag/data arrays and a request/response handshake toward the core.
On a miss, a refill FSM fetches a full line over a beat-serial memory interface, then returns the requested word.
It adds flush, saturating hit/miss statistics, and generic line size and depth.
It sits between the load path and the backing memory model.

Parameters:
ADDR_W, 15, word-address width of req_addr.
DATA_W, 32, word width.
WORDS, 4, words per line; power of two, >= 2; OFF_W = log2(WORDS).
LINES, 1024, number of lines; power of two; IDX_W = log2(LINES); TAG_W = ADDR_W - IDX_W - OFF_W, must be >= 1.
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
flush  in  1  pulse; invalidate all lines.
req_valid  in  1  core read request valid.
req_ready  out  1  controller can accept a request.
req_addr  in  ADDR_W  word address: [OFF_W-1:0] word select, [OFF_W+IDX_W-1:OFF_W] index, top TAG_W bits tag.
resp_valid  out  1  one-cycle pulse; resp_data is valid. No backpressure.
resp_data  out  DATA_W  requested word.
resp_hit  out  1  qualifies resp_valid: 1 = hit, 0 = serviced by refill.
mem_req_valid  out  1  line fetch request.
mem_req_ready  in  1  memory accepts the fetch.
mem_req_addr  out  ADDR_W  line-aligned address; low OFF_W bits are 0.
mem_rsp_valid  in  1  one refill beat valid.
mem_rsp_data  in  DATA_W  refill beat; beat k is word k of the line.
hit_cnt  out  CNT_W  number of hits.
miss_cnt  out  CNT_W  number of misses.

Behaviour:
- Reset (rst=0 at an edge):
  - FSM goes to IDLE and all valid bits clear.
  - req_ready=1; resp_valid, resp_hit, mem_req_valid = 0; resp_data, mem_req_addr = 0.
  - Counters = 0; pending flush and beat counter clear.
  - Tag and data arrays are not cleared.
  - Reset in any state, including mid-refill, aborts the operation. The partial line is discarded and no response is issued.
- FSM states: IDLE, LOOKUP, MREQ, REFILL, RESP.
- IDLE:
  - req_ready = 1 unless flush or a pending flush is present.
  - On acceptance (req_valid & req_ready), register the address and go to LOOKUP.
  - mem_rsp_valid is ignored in IDLE, so stale beats after a reset are dropped.
- LOOKUP: hit = valid[idx] & (tag_arr[idx] == tag).
  - On a hit: next cycle resp_valid=1, resp_hit=1, resp_data=word; hit_cnt+1; return to IDLE.
  - Hit latency is a response 2 cycles after the acceptance edge. Back-to-back hits give one accepted request per 2 cycles.
  - On a miss: miss_cnt+1; go to MREQ.
- MREQ:
  - mem_req_valid=1 and mem_req_addr={tag,idx,OFF_W'b0}, both held stable until mem_req_ready.
  - On handshake go to REFILL with beat=0.
- REFILL:
  - Each mem_rsp_valid writes beat data to word[beat] of the line buffer; beat increments.
  - Gaps between beats are allowed.
  - On the WORDS-th beat, write data, tag and valid=1 into line idx. Any previous contents are evicted silently.
  - Then go to RESP.
- RESP: resp_valid=1, resp_hit=0, resp_data=refilled word[sel]; return to IDLE.
- Flush:
  - In IDLE, a flush clears all valid bits at that edge. It beats a same-cycle req_valid, which is not accepted.
  - A flush in any other state sets a pending flag. The flag executes on the first IDLE cycle, and req_ready=0 during that cycle.
  - The current operation completes and installs its line before the flush executes.
- Counters saturate at 2^CNT_W-1; they do not wrap.
- resp_valid never asserts except the cycle after LOOKUP-hit or in RESP.

Optional Feature:
STATS_EN.
- Defined: hit_cnt and miss_cnt behave as above.
- Undefined: the counter logic is removed and hit_cnt and miss_cnt are tied to 0. The port list is unchanged.

Test Plan:
1. Reset with rst=0 for 2 cycles, then read 0x0004 -> miss.
   - mem_req_addr=0x0004; beats 10,12,14,16 return.
   - Response resp_data=10, resp_hit=0; miss_cnt=1.
2. After test 1, read 0x0006 -> resp_hit=1, resp_data=14, 2 cycles after acceptance; hit_cnt=1.
3. Conflict case: read 0x1004 (same index, tag differs) -> miss and refill with beats 100..103; resp_data=100.
   - A following read of 0x0004 misses again; miss_cnt=3.
4. Hold mem_req_ready=0 for 5 cycles and insert 2-cycle gaps between beats.
   - mem_req_valid and mem_req_addr stay stable; exactly one response is issued with the correct word.
5. Assert flush during REFILL.
   - The response completes.
   - The next IDLE cycle has req_ready=0.
   - A subsequent read of the same address misses.
6. Drive rst=0 after beat 2 of a refill.
   - No response is issued and counters = 0.
   - Remaining beats are ignored.
   - A re-read misses and returns correct data.
   - Also run with hit_cnt forced to max -> it stays at max.

Source files
------------

// File: rtl/dm_cache_ctrl_if.sv
// Core/memory bus bundle for the direct-mapped cache controller.
// The slave modport is the controller side. The master modport is the side
// that owns the load path and the backing memory model.
interface dm_cache_ctrl_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_hit;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;

  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data,
    output resp_hit,
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data
  );

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data,
    input  resp_hit,
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data
  );

endinterface

// File: rtl/dm_cache_ctrl.sv
// Read-only direct-mapped cache controller.
// Hits respond one cycle after lookup. Misses fetch a whole line beat by beat,
// install it, and then return the requested word. A flush that arrives while
// busy is deferred until the controller is back in IDLE.
// Optional macro STATS_EN: when it is defined, saturating hit/miss counters
// are built. When it is undefined, hit_cnt and miss_cnt are tied to zero.
module dm_cache_ctrl #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4,
  parameter int LINES  = 1024,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  dm_cache_ctrl_if.slave   bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MREQ,
    REFILL,
    RESP
  } state_t;

  typedef logic [WORDS-1:0][DATA_W-1:0] line_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LINES-1:0]  valid_q;
  logic              flush_pend;
  logic [OFF_W-1:0]  beat;

  logic              resp_valid_q;
  logic              resp_hit_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              mem_req_valid_q;
  logic [ADDR_W-1:0] mem_req_addr_q;

  logic [TAG_W-1:0]  tag_arr  [LINES];
  line_t             data_arr [LINES];
  line_t             line_buf;
  line_t             fill_line;

  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [OFF_W-1:0]  sel_q;
  logic              lookup_hit;
  logic              fill_done;

  assign tag_q = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_q = addr_q[OFF_W +: IDX_W];
  assign sel_q = addr_q[OFF_W-1:0];

  assign lookup_hit = valid_q[idx_q] && (tag_arr[idx_q] == tag_q);
  assign fill_done  = (state == REFILL) && bus.mem_rsp_valid && (beat == LAST_BEAT);

  // Full line as it will be installed: buffered beats plus the final beat on the bus.
  always_comb begin
    fill_line = {bus.mem_rsp_data, line_buf[WORDS-2:0]};
  end

  assign bus.req_ready     = (state == IDLE) && !flush && !flush_pend;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_hit      = resp_hit_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = mem_req_addr_q;

  // Collect refill beats into the line buffer; contents need no reset.
  always_ff @(posedge clk) begin
    if ((state == REFILL) && bus.mem_rsp_valid) begin
      line_buf[beat] <= bus.mem_rsp_data;
    end
  end

  // Install the completed line into the tag and data arrays; a reset on the same edge discards it.
  always_ff @(posedge clk) begin
    if (rst && fill_done) begin
      tag_arr[idx_q]  <= tag_q;
      data_arr[idx_q] <= fill_line;
    end
  end

  // Main controller FSM: handshake, lookup, refill sequencing, valid bits and flush handling.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      addr_q          <= '0;
      valid_q         <= '0;
      flush_pend      <= 1'b0;
      beat            <= '0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_data_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;

      if (flush && (state != IDLE)) begin
        flush_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (flush || flush_pend) begin
            valid_q    <= '0;
            flush_pend <= 1'b0;
          end else if (bus.req_valid) begin
            addr_q <= bus.req_addr;
            state  <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (lookup_hit) begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b1;
            resp_data_q  <= data_arr[idx_q][sel_q];
            state        <= IDLE;
          end else begin
            mem_req_valid_q <= 1'b1;
            mem_req_addr_q  <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            state           <= MREQ;
          end
        end

        MREQ: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            beat            <= '0;
            state           <= REFILL;
          end
        end

        REFILL: begin
          if (bus.mem_rsp_valid) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              valid_q[idx_q] <= 1'b1;
              resp_valid_q   <= 1'b1;
              resp_hit_q     <= 1'b0;
              resp_data_q    <= fill_line[sel_q];
              state          <= RESP;
            end
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef STATS_EN
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  // Saturating hit/miss statistics, updated once per lookup.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state == LOOKUP) begin
      if (lookup_hit) begin
        if (hit_cnt_q != {CNT_W{1'b1}}) begin
          hit_cnt_q <= hit_cnt_q + 1'b1;
        end
      end else begin
        if (miss_cnt_q != {CNT_W{1'b1}}) begin
          miss_cnt_q <= miss_cnt_q + 1'b1;
        end
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed self-checking bench for dm_cache_ctrl.
// The counters are narrowed to 2 bits so that saturation is reached quickly.
// The expected counter values follow the STATS_EN build option.
module tb_dm_cache_ctrl;

  localparam int ADDR_W  = 15;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef STATS_EN
  localparam logic [31:0] STATS_MASK = '1;
`else
  localparam logic [31:0] STATS_MASK = '0;
`endif

  logic             clk   = 1'b0;
  logic             rst   = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  int compared   = 0;
  int mismatched = 0;
  int exp_hit    = 0;
  int exp_miss   = 0;

  dm_cache_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dm_cache_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .WORDS (4),
    .LINES (1024),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .bus     (bus),
    .hit_cnt (hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] expCnt(input int v);
    return 32'(v) & STATS_MASK;
  endfunction

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_hit_cnt"}, 32'(hit_cnt), expCnt(exp_hit));
    checkOutput({tag, "_miss_cnt"}, 32'(miss_cnt), expCnt(exp_miss));
  endtask

  // Read that must hit: response exactly two cycles after the acceptance edge.
  task automatic applyHitRead(input string tag, input logic [ADDR_W-1:0] addr, input logic [31:0] exp_word);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    #1 checkOutput({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput({tag, "_early_resp"}, 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    if (exp_hit < CNT_MAX) exp_hit++;
    checkOutput({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
    checkOutput({tag, "_resp_hit"}, 32'(bus.resp_hit), 32'd1);
    checkOutput({tag, "_resp_data"}, bus.resp_data, exp_word);
    checkOutput({tag, "_no_mreq"}, 32'(bus.mem_req_valid), 32'd0);
    checkCounters(tag);
  endtask

  // Read that must miss. The memory side is driven with programmable ready delay, beat gaps,
  // an optional flush pulse before a chosen beat, and an optional reset after a chosen beat.
  task automatic applyMissRead(input string tag, input logic [ADDR_W-1:0] addr,
                               input logic [ADDR_W-1:0] line_addr, input logic [31:0] base,
                               input logic [31:0] step, input logic [31:0] exp_word,
                               input int rdy_delay, input int gap, input int flush_beat,
                               input int abort_beat);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    #1 checkOutput({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput({tag, "_lookup_busy"}, 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    if (exp_miss < CNT_MAX) exp_miss++;
    for (int i = 0; i < rdy_delay; i++) begin
      checkOutput({tag, "_mreq_hold_valid"}, 32'(bus.mem_req_valid), 32'd1);
      checkOutput({tag, "_mreq_hold_addr"}, 32'(bus.mem_req_addr), 32'(line_addr));
      @(negedge clk);
    end
    checkOutput({tag, "_mreq_valid"}, 32'(bus.mem_req_valid), 32'd1);
    checkOutput({tag, "_mreq_addr"}, 32'(bus.mem_req_addr), 32'(line_addr));
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    checkOutput({tag, "_mreq_drop"}, 32'(bus.mem_req_valid), 32'd0);
    checkCounters({tag, "_miss"});
    for (int k = 0; k < 4; k++) begin
      if (k == flush_beat) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
      for (int g = 0; g < gap; g++) begin
        checkOutput({tag, "_gap_resp"}, 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
      end
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = base + step * 32'(k);
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      if (k == abort_beat) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_hit  = 0;
        exp_miss = 0;
        checkOutput({tag, "_abort_resp"}, 32'(bus.resp_valid), 32'd0);
        checkOutput({tag, "_abort_mreq"}, 32'(bus.mem_req_valid), 32'd0);
        checkCounters({tag, "_abort"});
        for (int j = k + 1; j < 4; j++) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = base + step * 32'(j);
          @(negedge clk);
          bus.mem_rsp_valid = 1'b0;
          checkOutput({tag, "_stale_resp"}, 32'(bus.resp_valid), 32'd0);
          checkOutput({tag, "_stale_ready"}, 32'(bus.req_ready), 32'd1);
        end
        return;
      end
    end
    checkOutput({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
    checkOutput({tag, "_resp_hit"}, 32'(bus.resp_hit), 32'd0);
    checkOutput({tag, "_resp_data"}, bus.resp_data, exp_word);
    @(negedge clk);
    checkOutput({tag, "_single_resp"}, 32'(bus.resp_valid), 32'd0);
    checkOutput({tag, "_idle_ready"}, 32'(bus.req_ready), (flush_beat >= 0) ? 32'd0 : 32'd1);
    if (flush_beat >= 0) begin
      @(negedge clk);
      checkOutput({tag, "_after_flush_ready"}, 32'(bus.req_ready), 32'd1);
    end
  endtask

  // Full directed sequence: reset, miss/hit, conflict, stalls, flushes, abort and saturation.
  task automatic applyStimulus();
    rst               = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_addr      = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_resp_hit", 32'(bus.resp_hit), 32'd0);
    checkOutput("rst_resp_data", bus.resp_data, 32'd0);
    checkOutput("rst_mreq_valid", 32'(bus.mem_req_valid), 32'd0);
    checkOutput("rst_mreq_addr", 32'(bus.mem_req_addr), 32'd0);
    checkCounters("rst");

    applyMissRead("t1_miss", 15'h0004, 15'h0004, 32'd10, 32'd2, 32'd10, 0, 0, -1, -1);
    applyHitRead("t2_hit", 15'h0006, 32'd14);
    applyMissRead("t3_conflict", 15'h1004, 15'h1004, 32'd100, 32'd1, 32'd100, 0, 0, -1, -1);
    applyMissRead("t3_evicted", 15'h0004, 15'h0004, 32'd10, 32'd2, 32'd10, 0, 0, -1, -1);
    applyMissRead("t4_stall", 15'h010B, 15'h0108, 32'hA0, 32'd1, 32'hA3, 5, 2, -1, -1);
    applyHitRead("t4_hit", 15'h0109, 32'hA1);

    applyMissRead("t5_flush", 15'h2210, 15'h2210, 32'hB0, 32'd1, 32'hB0, 0, 0, 2, -1);
    applyMissRead("t5_reread", 15'h2211, 15'h2210, 32'hB0, 32'd1, 32'hB1, 0, 0, -1, -1);
    applyMissRead("t5_old_line", 15'h0109, 15'h0108, 32'hA0, 32'd1, 32'hA1, 0, 0, -1, -1);

    flush         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 15'h2212;
    #1 checkOutput("t5_idle_flush_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    #1 checkOutput("t5_idle_flush_not_taken", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    checkOutput("t5_idle_flush_no_mreq", 32'(bus.mem_req_valid), 32'd0);
    checkOutput("t5_idle_flush_no_resp", 32'(bus.resp_valid), 32'd0);
    applyMissRead("t5_idle_flushed", 15'h2212, 15'h2210, 32'hC0, 32'd1, 32'hC2, 0, 0, -1, -1);

    applyMissRead("t6_abort", 15'h0004, 15'h0004, 32'd10, 32'd2, 32'd10, 0, 0, -1, 1);
    applyMissRead("t6_reread", 15'h0004, 15'h0004, 32'd10, 32'd2, 32'd10, 0, 1, -1, -1);
    applyHitRead("t6_hit1", 15'h0005, 32'd12);
    applyHitRead("t6_hit2", 15'h0006, 32'd14);
    applyHitRead("t6_hit3", 15'h0007, 32'd16);
    applyHitRead("t6_hit_sat", 15'h0004, 32'd10);
  endtask

  initial begin
    applyStimulus();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
